// File: rtl/cordic_atan2_seq.sv
// Sequential CORDIC vectoring core: atan2(y, x) in degrees, one micro-rotation per clock.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_x/in_y,
//        out_valid/out_ready/out_angle/out_mag, busy.
// Optional magnitude output enabled by defining CORDIC_MAG_EN; otherwise out_mag is 0.
module cordic_atan2_seq #(
    parameter int DATA_W   = 32,
    parameter int ANG_W    = 32,
    parameter int ANG_FRAC = 16,
    parameter int ITER     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ANG_W-1:0]  out_angle,
    output logic [DATA_W-1:0] out_mag,
    output logic              busy
);

    // Guard bits below the integer LSB keep small vectors accurate.
    localparam int GUARD = 16;
    localparam int W     = DATA_W + 2 + GUARD;
    localparam int ZW    = ANG_W + 1;
    localparam int CW    = 5;

    // Table is stored in Q.16 degrees and rescaled to ANG_FRAC.
    localparam int     SH_L = (ANG_FRAC >= 16) ? (ANG_FRAC - 16) : 0;
    localparam int     SH_R = (ANG_FRAC < 16) ? (16 - ANG_FRAC) : 0;
    localparam longint RND  = (longint'(1) <<< SH_R) >>> 1;

    localparam logic signed [ZW-1:0] Z_180  = ZW'(longint'(180) <<< ANG_FRAC);
    localparam logic signed [ZW-1:0] Z_N180 = -Z_180;
    localparam logic signed [ZW-1:0] Z_360  = ZW'(longint'(360) <<< ANG_FRAC);
    localparam logic [CW-1:0]        LAST   = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] i);
        longint b;
        case (i)
            5'd0:    b = 2949120;
            5'd1:    b = 1740967;
            5'd2:    b = 919879;
            5'd3:    b = 466945;
            5'd4:    b = 234379;
            5'd5:    b = 117304;
            5'd6:    b = 58666;
            5'd7:    b = 29335;
            5'd8:    b = 14668;
            5'd9:    b = 7334;
            5'd10:   b = 3667;
            5'd11:   b = 1833;
            5'd12:   b = 917;
            5'd13:   b = 458;
            5'd14:   b = 229;
            5'd15:   b = 115;
            5'd16:   b = 57;
            5'd17:   b = 29;
            5'd18:   b = 14;
            5'd19:   b = 7;
            5'd20:   b = 4;
            5'd21:   b = 2;
            5'd22:   b = 1;
            default: b = 0;
        endcase
        return ZW'(((b <<< SH_L) + RND) >>> SH_R);
    endfunction

    state_t                state_q, state_d;
    logic signed [W-1:0]   x_q, x_d;
    logic signed [W-1:0]   y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  zero_q, zero_d;
    logic [ANG_W-1:0]      ang_q, ang_d;

    logic signed [W-1:0]   xe, ye;
    logic signed [W-1:0]   x_sh, y_sh;
    logic signed [W-1:0]   x_rot, y_rot;
    logic signed [ZW-1:0]  t_i;
    logic signed [ZW-1:0]  z_rot, z_wrap;

    // Input sign-extended and placed above the guard bits.
    assign xe = {{2{in_x[DATA_W-1]}}, in_x, {GUARD{1'b0}}};
    assign ye = {{2{in_y[DATA_W-1]}}, in_y, {GUARD{1'b0}}};

    assign x_sh = x_q >>> cnt_q;
    assign y_sh = y_q >>> cnt_q;
    assign t_i  = atan_lut(cnt_q);

    always_comb begin
        x_rot = x_q;
        y_rot = y_q;
        z_rot = z_q;
        if (!y_q[W-1]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + t_i;
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - t_i;
        end
    end

    // Fold into (-180, +180]; the lower fix-up only catches residual error.
    always_comb begin
        z_wrap = z_rot;
        if (z_rot == Z_N180) begin
            z_wrap = Z_180;
        end else if (z_rot > Z_180) begin
            z_wrap = z_rot - Z_360;
        end else if (z_rot < Z_N180) begin
            z_wrap = z_rot + Z_360;
        end
    end

`ifdef CORDIC_MAG_EN
    localparam int PW = W + 17;
    localparam logic signed [PW-1:0] KCOMP   = PW'(39797);
    localparam logic signed [PW-1:0] MRND    = PW'(1) <<< (15 + GUARD);
    localparam logic signed [PW-1:0] MAG_MAX =
        PW'((longint'(1) <<< (DATA_W - 1)) - 1);

    logic [DATA_W-1:0]     mag_q, mag_d;
    logic signed [PW-1:0]  prod, mag_r;
    logic [DATA_W-1:0]     mag_sat;

    // Gain compensation: x_final * K, rounded, guard bits dropped.
    assign prod    = PW'(x_rot) * KCOMP;
    assign mag_r   = (prod + MRND) >>> (16 + GUARD);
    assign mag_sat = (mag_r > MAG_MAX) ? MAG_MAX[DATA_W-1:0]
                                       : mag_r[DATA_W-1:0];
    assign out_mag = mag_q;
`else
    assign out_mag = '0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_angle = ang_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        ang_d   = ang_q;
`ifdef CORDIC_MAG_EN
        mag_d   = mag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d   = '0;
                    zero_d  = (in_x == '0) && (in_y == '0);
                    state_d = ROT;
                    if (!xe[W-1]) begin
                        x_d = xe;
                        y_d = ye;
                        z_d = '0;
                    end else begin
                        x_d = -xe;
                        y_d = -ye;
                        z_d = ye[W-1] ? Z_N180 : Z_180;
                    end
                end
            end
            ROT: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    ang_d   = zero_q ? '0 : z_wrap[ANG_W-1:0];
`ifdef CORDIC_MAG_EN
                    mag_d   = zero_q ? '0 : mag_sat;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            ang_q   <= '0;
`ifdef CORDIC_MAG_EN
            mag_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            ang_q   <= ang_d;
`ifdef CORDIC_MAG_EN
            mag_q   <= mag_d;
`endif
        end
    end

endmodule
